// File: rtl/manchester_rx_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : manchester_rx_if
// Description : Sequence-memory write port driven by the Manchester receiver.
//               The master side (decoder) drives the word, its address and a
//               one-cycle write strobe; the slave side (memory) consumes them.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface manchester_rx_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 7
);
   logic [DATA_W-1:0] data_out;
   logic              data_wren;
   logic [ADDR_W-1:0] wr_addr;

   modport master (
      output data_out,
      output data_wren,
      output wr_addr
   );

   modport slave (
      input  data_out,
      input  data_wren,
      input  wr_addr
   );
endinterface
`default_nettype wire

// File: rtl/manchester_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : manchester_rx
// Description : Manchester frame decoder for the PA command link. Recovers
//               start bit + DATA_W data bits (MSB first) from an asynchronous
//               line, and writes each word to the sequence memory at an
//               auto-incrementing address that wraps at seq_end_addr.
//               Optional macro PARITY_CHECK_EN: when defined, an even-parity
//               bit follows the data bits and a mismatch is a framing error.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module manchester_rx #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 7,
   parameter int HALF_BIT = 8
) (
   input  wire                 clk,
   input  wire                 rst_n,
   input  wire                 rx_en,
   input  wire                 rx_in,
   input  wire  [ADDR_W-1:0]   seq_end_addr,
   manchester_rx_if.master     mem,
   output logic                frame_err,
   output logic                busy
);

   // Counter widths: cnt saturates at 4*HALF_BIT; bit_cnt must hold DATA_W+1
   localparam int c_cnt_w = $clog2(4 * HALF_BIT) + 1;
   localparam int c_bit_w = $clog2(DATA_W + 2) + 1;

`ifdef PARITY_CHECK_EN
   localparam int c_frame_bits = DATA_W + 1;
`else
   localparam int c_frame_bits = DATA_W;
`endif

   // Mid-bit acceptance window and idle qualification, integer division
   localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(4 * HALF_BIT);
   localparam logic [c_cnt_w-1:0] c_mid_lo   = c_cnt_w'(3 * HALF_BIT / 2);
   localparam logic [c_cnt_w-1:0] c_mid_hi   = c_cnt_w'(5 * HALF_BIT / 2);
   localparam logic [c_cnt_w-1:0] c_idle_end = c_cnt_w'(2 * HALF_BIT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_frame_bits - 1);
   localparam logic [c_bit_w-1:0] c_bit_data = c_bit_w'(DATA_W);
   localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
   localparam logic [ADDR_W-1:0]  c_addr_one = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DATA      = 3'd1,
      S_DONE      = 3'd2,
      S_WAIT_IDLE = 3'd3,
      S_ERR       = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_sync1;
   logic                r_sync2;
   logic                r_sync_prev;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [c_cnt_w-1:0]  r_low_cnt;
   logic [c_bit_w-1:0]  r_bit_cnt;
   logic [DATA_W-1:0]   r_shift;
   logic [DATA_W-1:0]   r_data_out;
   logic                r_wren;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_frame_err;
`ifdef PARITY_CHECK_EN
   logic                r_par;
`endif

   logic                w_edge;
   logic                w_rise;
   logic                w_mid_edge;
   logic                w_timeout;
   logic                w_last_bit;
   logic                w_par_bad;
   logic                w_low_done;
   logic                w_start;
   logic                w_load;
   logic                w_err;

   // Edge detection on the synchronized line; mid-bit qualification by cnt
   assign w_edge     = r_sync2 ^ r_sync_prev;
   assign w_rise     = r_sync2 & ~r_sync_prev;
   assign w_mid_edge = (r_state == S_DATA) && w_edge &&
                       (r_cnt >= c_mid_lo) && (r_cnt <= c_mid_hi);
   assign w_timeout  = (r_state == S_DATA) && (r_cnt > c_mid_hi);
   assign w_last_bit = w_mid_edge && (r_bit_cnt == c_bit_last);
   assign w_low_done = !r_sync2 && (r_low_cnt == c_idle_end);

`ifdef PARITY_CHECK_EN
   // Even parity: XOR of data bits and the parity bit itself must be 0
   assign w_par_bad  = r_par ^ w_rise;
`else
   assign w_par_bad  = 1'b0;
`endif

   assign busy          = (r_state != S_IDLE);
   assign frame_err     = r_frame_err;
   assign mem.data_out  = r_data_out;
   assign mem.data_wren = r_wren;
   assign mem.wr_addr   = r_addr;

   // Two-flop synchronizer plus previous-value flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_sync_prev <= 1'b0;
      end else begin
         r_sync1     <= rx_in;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state and control strobes; rx_en low forces IDLE from anywhere
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_err       = 1'b0;
      if (!rx_en) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  w_start     = 1'b1;
                  w_state_nxt = S_DATA;
               end
            end
            S_DATA: begin
               if (w_timeout) begin
                  w_state_nxt = S_ERR;
               end else if (w_last_bit) begin
                  w_state_nxt = w_par_bad ? S_ERR : S_DONE;
               end
            end
            S_DONE: begin
               w_load      = 1'b1;
               w_state_nxt = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
               if (w_low_done) begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_ERR: begin
               w_err       = 1'b1;
               w_state_nxt = S_WAIT_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Datapath: timing counters, shift register, output word and address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_low_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_data_out  <= '0;
         r_wren      <= 1'b0;
         r_addr      <= '0;
         r_frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
         r_par       <= 1'b0;
`endif
      end else begin
         r_wren      <= 1'b0;
         r_frame_err <= 1'b0;
         if (!rx_en) begin
            // Abort: drop the frame and restart addressing; data_out is held
            r_cnt     <= '0;
            r_low_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
`ifdef PARITY_CHECK_EN
            r_par     <= 1'b0;
`endif
         end else begin
            // cnt runs only in DATA, restarts on every accepted mid-bit edge
            if ((r_state == S_DATA) && !w_mid_edge) begin
               if (r_cnt != c_cnt_sat) begin
                  r_cnt <= r_cnt + c_cnt_one;
               end
            end else begin
               r_cnt <= '0;
            end

            // Consecutive low samples while waiting for the line to settle
            if ((r_state == S_WAIT_IDLE) && !r_sync2) begin
               r_low_cnt <= r_low_cnt + c_cnt_one;
            end else begin
               r_low_cnt <= '0;
            end

            if (w_start || w_err) begin
               r_bit_cnt <= '0;
               r_shift   <= '0;
`ifdef PARITY_CHECK_EN
               r_par     <= 1'b0;
`endif
            end else if (w_mid_edge) begin
               r_bit_cnt <= r_bit_cnt + c_bit_one;
               // Only data bits enter the word; a trailing parity bit does not
               if (r_bit_cnt < c_bit_data) begin
                  r_shift <= {r_shift[DATA_W-2:0], w_rise};
`ifdef PARITY_CHECK_EN
                  r_par   <= r_par ^ w_rise;
`endif
               end
            end

            if (w_load) begin
               r_data_out <= r_shift;
               r_wren     <= 1'b1;
            end

            if (w_err) begin
               r_frame_err <= 1'b1;
            end

            // Address advances the cycle after the write strobe
            if (r_wren) begin
               r_addr <= (r_addr == seq_end_addr) ? '0 : r_addr + c_addr_one;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_manchester_rx.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module      : tb_manchester_rx
// Description : Directed self-checking bench for manchester_rx. Expected
//               words and addresses are queued when a frame is sent and
//               compared when the decoder strobes data_wren.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_manchester_rx;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 7;
   localparam int HALF_BIT = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              rx_en;
   logic              rx_in;
   logic [ADDR_W-1:0] seq_end_addr;
   logic              frame_err;
   logic              busy;

   manchester_rx_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   manchester_rx #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .HALF_BIT (HALF_BIT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_en        (rx_en),
      .rx_in        (rx_in),
      .seq_end_addr (seq_end_addr),
      .mem          (bus),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests    = 0;
   int   n_fail     = 0;
   int   err_cycles = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_word(input logic [DATA_W-1:0] w, input logic [ADDR_W-1:0] a);
      sb_q.push_back({w, a});
   endtask

   task automatic drive(input logic v, input int cyc);
      rx_in = v;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic wait_cyc(input int cyc);
      repeat (cyc) @(negedge clk);
   endtask

   // mode 0: nominal half-bits; mode 1: jittered mid-bit spacing 13..19;
   // mode 2: mid-bit spacing of 22 cycles into bit gap_at, frame stops there.
   // n_data limits how many data bits are sent (partial frames).
   task automatic send_word(input logic [DATA_W-1:0] w, input int mode, input int gap_at,
                            input int n_data, input bit bad_par, input int idle_cyc);
      logic [31:0] bits;
      int          n;
      int          sent;
      int          h1;
      int          h2;
      bits = '0;
`ifdef PARITY_CHECK_EN
      n                = DATA_W + 2;
      bits[DATA_W+1]   = 1'b1;
      bits[DATA_W:1]   = w;
      bits[0]          = (^w) ^ bad_par;
`else
      n                = DATA_W + 1;
      bits[DATA_W]     = 1'b1;
      bits[DATA_W-1:0] = w;
`endif
      sent = 0;
      for (int i = n - 1; i >= 0; i--) begin
         if (sent == n_data + 1) break;
         h1 = HALF_BIT;
         h2 = HALF_BIT;
         if (mode == 1) begin
            h1 = int'($urandom_range(HALF_BIT + 1, HALF_BIT - 1));
            h2 = int'($urandom_range(HALF_BIT + 2, HALF_BIT - 2));
         end
         if (mode == 2 && i == gap_at) h1 = 22 - HALF_BIT;
         drive(~bits[i], h1);
         drive(bits[i], h2);
         sent++;
         if (mode == 2 && i == gap_at) break;
      end
      drive(1'b0, idle_cyc);
   endtask

   // Scoreboard side: every write strobe must match the oldest queued entry
   always @(negedge clk) begin
      exp_t e;
      if (frame_err === 1'b1) err_cycles++;
      if (bus.data_wren === 1'b1) begin
         chk("wren_pending", {31'b0, bus.data_wren}, {31'b0, sb_q.size() != 0});
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("wr_data", 32'(bus.data_out), 32'(e.data));
            chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      rx_en        = 1'b0;
      rx_in        = 1'b0;
      seq_end_addr = 7'd127;
      wait_cyc(3);

      // Reset state
      chk("rst_data_out",  32'(bus.data_out),  32'h0);
      chk("rst_wren",      32'(bus.data_wren), 32'h0);
      chk("rst_wr_addr",   32'(bus.wr_addr),   32'h0);
      chk("rst_frame_err", 32'(frame_err),     32'h0);
      chk("rst_busy",      32'(busy),          32'h0);

      rst_n = 1'b1;
      rx_en = 1'b1;
      wait_cyc(5);

      // Clean frame
      expect_word(16'hA5C3, 7'd0);
      send_word(16'hA5C3, 0, 0, 99, 1'b0, 24);
      chk("frame1_addr_next", 32'(bus.wr_addr),  32'd1);
      chk("frame1_data_out",  32'(bus.data_out), 32'hA5C3);

      // Asynchronous reset in the middle of a frame
      send_word(16'h1234, 0, 0, 6, 1'b0, 0);
      chk("midframe_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data_out",  32'(bus.data_out),  32'h0);
      chk("arst_wren",      32'(bus.data_wren), 32'h0);
      chk("arst_wr_addr",   32'(bus.wr_addr),   32'h0);
      chk("arst_frame_err", 32'(frame_err),     32'h0);
      chk("arst_busy",      32'(busy),          32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(4);
      expect_word(16'hA5C3, 7'd0);
      send_word(16'hA5C3, 0, 0, 99, 1'b0, 24);
      chk("post_rst_addr", 32'(bus.wr_addr), 32'd1);

      // Address wrap at seq_end_addr = 2
      rx_en = 1'b0;
      wait_cyc(2);
      chk("abort_holds_data", 32'(bus.data_out), 32'hA5C3);
      chk("abort_clr_addr",   32'(bus.wr_addr),  32'd0);
      rx_en        = 1'b1;
      seq_end_addr = 7'd2;
      wait_cyc(2);
      expect_word(16'h0001, 7'd0);
      send_word(16'h0001, 0, 0, 99, 1'b0, 24);
      expect_word(16'h0002, 7'd1);
      send_word(16'h0002, 0, 0, 99, 1'b0, 24);
      expect_word(16'h0003, 7'd2);
      send_word(16'h0003, 0, 0, 99, 1'b0, 24);
      expect_word(16'h0004, 7'd0);
      send_word(16'h0004, 0, 0, 99, 1'b0, 24);
      chk("wrap_addr_next", 32'(bus.wr_addr), 32'd1);

      // Jittered mid-bit spacing within tolerance
      seq_end_addr = 7'd127;
      expect_word(16'h3C96, 7'd1);
      send_word(16'h3C96, 1, 0, 99, 1'b0, 24);
      expect_word(16'hB00B, 7'd2);
      send_word(16'hB00B, 1, 0, 99, 1'b0, 24);
      chk("jitter_addr_next", 32'(bus.wr_addr), 32'd3);
      chk("no_err_so_far",    32'(err_cycles),  32'd0);

      // Missing transition: 22-cycle mid-bit spacing
      send_word(16'h5A5A, 2, 10, 99, 1'b0, 24);
      chk("gap_err_pulse", 32'(err_cycles),  32'd1);
      chk("gap_addr_kept", 32'(bus.wr_addr), 32'd3);
      chk("gap_busy_idle", 32'(busy),        32'd0);

      // Abort after 8 data bits
      send_word(16'h0F0F, 0, 0, 8, 1'b0, 0);
      chk("abort_busy_before", 32'(busy), 32'd1);
      rx_en = 1'b0;
      @(negedge clk);
      chk("abort_busy_after", 32'(busy),        32'd0);
      chk("abort_addr_after", 32'(bus.wr_addr), 32'd0);
      rx_en = 1'b1;
      wait_cyc(4);
      expect_word(16'hFFFF, 7'd0);
      send_word(16'hFFFF, 0, 0, 99, 1'b0, 24);
      chk("reenable_addr_next", 32'(bus.wr_addr), 32'd1);

      // Back-to-back frames, exactly 2*HALF_BIT idle-low between them
      rx_en = 1'b0;
      wait_cyc(2);
      rx_en = 1'b1;
      wait_cyc(2);
      expect_word(16'h0000, 7'd0);
      send_word(16'h0000, 0, 0, 99, 1'b0, 2 * HALF_BIT);
      expect_word(16'hFFFF, 7'd1);
      send_word(16'hFFFF, 0, 0, 99, 1'b0, 24);
      chk("b2b_addr_next", 32'(bus.wr_addr), 32'd2);

      // seq_end_addr = 0: every word lands at address 0
      rx_en = 1'b0;
      wait_cyc(2);
      rx_en        = 1'b1;
      seq_end_addr = 7'd0;
      wait_cyc(2);
      expect_word(16'h1357, 7'd0);
      send_word(16'h1357, 0, 0, 99, 1'b0, 24);
      expect_word(16'h2468, 7'd0);
      send_word(16'h2468, 0, 0, 99, 1'b0, 24);
      chk("end0_addr", 32'(bus.wr_addr), 32'd0);

`ifdef PARITY_CHECK_EN
      // Parity: wrong bit rejected, correct bit accepted
      seq_end_addr = 7'd127;
      send_word(16'h8001, 0, 0, 99, 1'b1, 24);
      chk("par_bad_err",  32'(err_cycles),  32'd2);
      chk("par_bad_addr", 32'(bus.wr_addr), 32'd0);
      expect_word(16'h8001, 7'd0);
      send_word(16'h8001, 0, 0, 99, 1'b0, 24);
      chk("par_ok_addr", 32'(bus.wr_addr), 32'd1);
      chk("par_err_total", 32'(err_cycles), 32'd2);
`else
      chk("err_total", 32'(err_cycles), 32'd1);
`endif

      wait_cyc(10);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
